// File: rtl/vx_writeback_scalar_pkg.sv
// ----------------------------------------------------------------------------
// vx_writeback_scalar_pkg
// Shared types for the scalar writeback path. wb_beat_t is the result beat
// format that the execute units drive and that the writeback bus carries.
// Lane/uuid/register widths live here because the beat struct is shared by
// every producer and consumer.
// ----------------------------------------------------------------------------
package vx_writeback_scalar_pkg;

   localparam int THREAD_CNT = 4;
   localparam int XLEN       = 32;
   localparam int WIS_W      = 2;
   localparam int UUID_W     = 8;
   localparam int NR_W       = 5;

   // Lock state of the writeback arbiter: free to pick any source, or
   // held by one source until that source's end-of-packet beat.
   typedef enum logic {
      LOCK_FREE = 1'b0,
      LOCK_HELD = 1'b1
   } lockState_e;

   // One result beat as produced by an execute unit.
   typedef struct packed {
      logic [UUID_W-1:0]                uuid;
      logic [WIS_W-1:0]                 wis;
      logic [THREAD_CNT-1:0]            tmask;
      logic [XLEN-1:0]                  pc;
      logic                             wb;
      logic [NR_W-1:0]                  rd;
      logic [THREAD_CNT-1:0][XLEN-1:0]  data;
      logic                             sop;
      logic                             eop;
   } wb_beat_t;

endpackage

// File: rtl/vx_writeback_scalar_if.sv
// ----------------------------------------------------------------------------
// vx_writeback_scalar_if
// Groups the per-source result beats and the registered writeback bus.
//   src_valid / src_ready / src_beat : NUM_SRC execute-unit result ports
//   wb_valid / wb_beat                : registered writeback bus (no backpressure)
// master : the writeback block (consumes src_*, drives src_ready and wb_*)
// slave  : the environment (execute units drive src_*, collector reads wb_*)
// ----------------------------------------------------------------------------
interface vx_writeback_scalar_if
   import vx_writeback_scalar_pkg::*;
#(
   parameter int NUM_SRC = 4
);

   logic [NUM_SRC-1:0] src_valid;
   logic [NUM_SRC-1:0] src_ready;
   wb_beat_t           src_beat [NUM_SRC];
   logic               wb_valid;
   wb_beat_t           wb_beat;

   modport master (
      input  src_valid,
      input  src_beat,
      output src_ready,
      output wb_valid,
      output wb_beat
   );

   modport slave (
      output src_valid,
      output src_beat,
      input  src_ready,
      input  wb_valid,
      input  wb_beat
   );

endinterface

// File: rtl/vx_writeback_scalar_arbiter.sv
// ----------------------------------------------------------------------------
// vx_wb_lock_arbiter
// Round-robin arbiter with packet lock. Owns the round-robin pointer and the
// lock state so that a multi-beat packet stays contiguous on the bus.
//   clk, reset_n : clock, asynchronous active-low reset
//   valid_i      : per-source beat valid
//   accept_i     : the granted beat is taken this cycle
//   eop_i        : end-of-packet flag of the granted beat
//   grant_o      : one-hot grant (only ever set on a valid source)
//   locked_o     : a packet is in progress
// ----------------------------------------------------------------------------
module vx_wb_lock_arbiter
   import vx_writeback_scalar_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] valid_i,
   input  logic               accept_i,
   input  logic               eop_i,
   output logic [NUM_SRC-1:0] grant_o,
   output logic               locked_o
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   lockState_e       lockState_q, lockState_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0] grantIdx;
   logic             found;
   int               idx;

   // Grant selection: a held lock only lets its owner through; otherwise
   // search upward from the slot after the last packet's source, wrapping.
   always_comb begin
      grant_o  = '0;
      grantIdx = '0;
      found    = 1'b0;
      idx      = 0;
      if (lockState_q == LOCK_HELD) begin
         if (valid_i[owner_q]) begin
            grant_o[owner_q] = 1'b1;
            grantIdx         = owner_q;
         end
      end else begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(rrPtr_q) + k) % NUM_SRC;
            if (!found && valid_i[idx]) begin
               found         = 1'b1;
               grant_o[idx]  = 1'b1;
               grantIdx      = IDX_W'(idx);
            end
         end
      end
   end

   // Lock tracking: a beat without eop pins the bus to its source; the eop
   // beat frees it and moves the round-robin pointer to that source.
   always_comb begin
      lockState_d = lockState_q;
      owner_d     = owner_q;
      rrPtr_d     = rrPtr_q;
      if (accept_i) begin
         if (eop_i) begin
            lockState_d = LOCK_FREE;
            rrPtr_d     = grantIdx;
         end else begin
            lockState_d = LOCK_HELD;
            owner_d     = grantIdx;
         end
      end
   end

   // The pointer resets to the last source so source 0 wins first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lockState_q <= LOCK_FREE;
         owner_q     <= '0;
         rrPtr_q     <= IDX_W'(NUM_SRC - 1);
      end else begin
         lockState_q <= lockState_d;
         owner_q     <= owner_d;
         rrPtr_q     <= rrPtr_d;
      end
   end

   assign locked_o = (lockState_q == LOCK_HELD);

endmodule

// File: rtl/vx_writeback_scalar.sv
// ----------------------------------------------------------------------------
// vx_writeback_scalar
// Writeback master for one issue slot: arbitrates result beats from NUM_SRC
// execute units onto one registered writeback bus, keeps packets contiguous,
// drops beats with wb=0 and counts the beats it emits.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : master side of vx_writeback_scalar_if (src_* in, wb_* out)
//   wb_count     : number of emitted beats, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module vx_writeback_scalar
   import vx_writeback_scalar_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int CNT_W   = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   vx_writeback_scalar_if.master bus,
   output logic [CNT_W-1:0]      wb_count
);

   logic [NUM_SRC-1:0] grant;
   logic               locked;
   logic               accept;
   logic               emit;
   wb_beat_t           selBeat;

   logic               wbValid_q;
   wb_beat_t           wbBeat_q;
   logic [CNT_W-1:0]   wbCount_q;

   vx_wb_lock_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arbiter (
      .clk      (clk),
      .reset_n  (reset_n),
      .valid_i  (bus.src_valid),
      .accept_i (accept),
      .eop_i    (selBeat.eop),
      .grant_o  (grant),
      .locked_o (locked)
   );

   // Grant is already qualified by valid, so it doubles as src_ready.
   always_comb begin
      selBeat = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) begin
            selBeat = bus.src_beat[i];
         end
      end
   end

   assign accept        = |grant;
   assign emit          = accept & selBeat.wb;
   assign bus.src_ready = grant;

   // Output stage: only written beats load the data register, so dropped
   // beats and idle cycles leave the last emitted beat on the bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wbValid_q <= 1'b0;
         wbBeat_q  <= '0;
         wbCount_q <= '0;
      end else begin
         wbValid_q <= emit;
         if (emit) begin
            wbBeat_q  <= selBeat;
            wbCount_q <= wbCount_q + CNT_W'(1);
         end
      end
   end

   // A new packet start from the lock owner means the producer lost track
   // of its own packet boundary.
   always_ff @(posedge clk) begin
      if (reset_n && locked && accept) begin
         assert (!selBeat.sop);
      end
   end

   assign bus.wb_valid = wbValid_q;
   assign bus.wb_beat  = wbBeat_q;
   assign wb_count     = wbCount_q;

endmodule

// File: tb/tb_vx_writeback_scalar.sv
// ----------------------------------------------------------------------------
// tb_vx_writeback_scalar
// Self-checking bench for vx_writeback_scalar (NUM_SRC=4, CNT_W=4).
// Inputs change on the falling edge; the grant is checked 1 time unit later
// and the expected bus state is queued, then popped and compared on the next
// falling edge after the DUT has registered the beat.
// ----------------------------------------------------------------------------
module tb_vx_writeback_scalar;
   import vx_writeback_scalar_pkg::*;

   localparam int NSRC = 4;
   localparam int CNTW = 4;

   typedef struct {
      logic             v;
      wb_beat_t         b;
      logic [CNTW-1:0]  cnt;
   } expEntry_t;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [CNTW-1:0] wbCount;

   int              cmpCount = 0;
   int              errCount = 0;

   expEntry_t       sb [$];
   wb_beat_t        stim [NSRC];
   logic            mLocked;
   int              mOwner;
   int              mRr;
   logic [CNTW-1:0] mCount;
   wb_beat_t        mHeld;
   logic [NSRC-1:0] rdy;
   logic [CNTW-1:0] savedCount;

   vx_writeback_scalar_if #(.NUM_SRC(NSRC)) bus ();

   vx_writeback_scalar #(
      .NUM_SRC (NSRC),
      .CNT_W   (CNTW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .wb_count (wbCount)
   );

   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      cmpCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Beat builder: fields derived from source and tag so every beat differs.
   function automatic wb_beat_t mkBeat(input int src, input int tag, input logic wb,
                                       input logic sop, input logic eop);
      wb_beat_t b;
      b.uuid  = UUID_W'(tag);
      b.wis   = WIS_W'(src);
      b.tmask = THREAD_CNT'(tag + 1);
      b.pc    = XLEN'(32'h1000 + tag * 4);
      b.wb    = wb;
      b.rd    = NR_W'(tag + src);
      for (int l = 0; l < THREAD_CNT; l++) begin
         b.data[l] = XLEN'((src << 24) | (tag << 8) | l);
      end
      b.sop = sop;
      b.eop = eop;
      return b;
   endfunction

   task automatic applyStimulus(input logic [NSRC-1:0] v);
      bus.src_valid = v;
      for (int i = 0; i < NSRC; i++) begin
         bus.src_beat[i] = stim[i];
      end
   endtask

   task automatic modelReset();
      mLocked = 1'b0;
      mOwner  = 0;
      mRr     = NSRC - 1;
      mCount  = '0;
      mHeld   = '0;
   endtask

   // One clock of traffic: predict the grant, check src_ready, queue the
   // expected bus state, then compare it after the register stage.
   task automatic step(output logic [NSRC-1:0] rdyObs);
      int              g;
      int              idx;
      logic [NSRC-1:0] expRdy;
      expEntry_t       e;
      expEntry_t       got;
      #1;
      g = -1;
      if (mLocked) begin
         if (bus.src_valid[mOwner]) g = mOwner;
      end else begin
         for (int k = 1; k <= NSRC; k++) begin
            idx = (mRr + k) % NSRC;
            if (g < 0 && bus.src_valid[idx]) g = idx;
         end
      end
      expRdy = '0;
      if (g >= 0) expRdy[g] = 1'b1;
      rdyObs = bus.src_ready;
      checkOutput("src_ready", 256'(bus.src_ready), 256'(expRdy));
      e.v = 1'b0;
      if (g >= 0) begin
         if (stim[g].wb) begin
            e.v    = 1'b1;
            mHeld  = stim[g];
            mCount = mCount + 1'b1;
         end
         if (stim[g].eop) begin
            mLocked = 1'b0;
            mRr     = g;
         end else begin
            mLocked = 1'b1;
            mOwner  = g;
         end
      end
      e.b   = mHeld;
      e.cnt = mCount;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = sb.pop_front();
      checkOutput("wb_valid", 256'(bus.wb_valid), 256'(got.v));
      checkOutput("wb_beat", 256'(bus.wb_beat), 256'(got.b));
      checkOutput("wb_count", 256'(wbCount), 256'(got.cnt));
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      applyStimulus('0);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < NSRC; i++) stim[i] = '0;
      modelReset();
      applyStimulus('0);
      repeat (2) @(negedge clk);
      checkOutput("rst_wb_valid", 256'(bus.wb_valid), 256'(1'b0));
      checkOutput("rst_wb_beat", 256'(bus.wb_beat), 256'(0));
      checkOutput("rst_wb_count", 256'(wbCount), 256'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Single beat with hand-picked fields.
      stim[0]       = '0;
      stim[0].wb    = 1'b1;
      stim[0].wis   = 2'd1;
      stim[0].rd    = 5'd5;
      stim[0].tmask = 4'b1011;
      for (int l = 0; l < THREAD_CNT; l++) stim[0].data[l] = XLEN'(l * 32'h10);
      stim[0].sop   = 1'b1;
      stim[0].eop   = 1'b1;
      applyStimulus(4'b0001);
      step(rdy);
      checkOutput("single_rdy", 256'(rdy), 256'(4'b0001));
      checkOutput("single_rd", 256'(bus.wb_beat.rd), 256'(5'd5));
      checkOutput("single_lane2", 256'(bus.wb_beat.data[2]), 256'(32'h20));
      checkOutput("single_cnt", 256'(wbCount), 256'(4'd1));

      // Contention among sources 0..2; pointer sits at 0, so 1 goes first.
      for (int i = 0; i < 6; i++) begin
         for (int s = 0; s < 3; s++) stim[s] = mkBeat(s, 10 + i, 1'b1, 1'b1, 1'b1);
         applyStimulus(4'b0111);
         step(rdy);
         checkOutput("cont_grant", 256'(rdy), 256'(4'b0001 << ((i + 1) % 3)));
         checkOutput("cont_nogap", 256'(bus.wb_valid), 256'(1'b1));
      end

      // Packet lock: source 1 holds the bus for three beats while 0 waits.
      stim[0] = mkBeat(0, 30, 1'b1, 1'b1, 1'b1);
      stim[1] = mkBeat(1, 31, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0011);
      step(rdy);
      checkOutput("lock_b0", 256'(rdy), 256'(4'b0010));
      stim[1] = mkBeat(1, 32, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0011);
      step(rdy);
      checkOutput("lock_b1", 256'(rdy), 256'(4'b0010));
      stim[1] = mkBeat(1, 33, 1'b1, 1'b0, 1'b1);
      applyStimulus(4'b0011);
      step(rdy);
      checkOutput("lock_b2", 256'(rdy), 256'(4'b0010));
      stim[2] = mkBeat(2, 34, 1'b1, 1'b1, 1'b1);
      applyStimulus(4'b0101);
      step(rdy);
      checkOutput("lock_rr_next", 256'(rdy), 256'(4'b0100));
      applyStimulus(4'b0001);
      step(rdy);
      checkOutput("lock_src0", 256'(rdy), 256'(4'b0001));

      // Dropped single beat, then a dropped beat that still locks the bus.
      savedCount = wbCount;
      stim[3] = mkBeat(3, 40, 1'b0, 1'b1, 1'b1);
      applyStimulus(4'b1000);
      step(rdy);
      checkOutput("drop_valid", 256'(bus.wb_valid), 256'(1'b0));
      checkOutput("drop_cnt", 256'(wbCount), 256'(savedCount));
      stim[3] = mkBeat(3, 41, 1'b0, 1'b1, 1'b0);
      applyStimulus(4'b1000);
      step(rdy);
      stim[0] = mkBeat(0, 42, 1'b1, 1'b1, 1'b1);
      stim[3] = mkBeat(3, 43, 1'b0, 1'b0, 1'b1);
      applyStimulus(4'b1001);
      step(rdy);
      checkOutput("drop_lock", 256'(rdy), 256'(4'b1000));

      // Idle cycle: bus goes quiet, data holds.
      applyStimulus('0);
      step(rdy);

      // Reset in the middle of a source-2 packet.
      stim[2] = mkBeat(2, 50, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0100);
      step(rdy);
      checkOutput("mid_pre_valid", 256'(bus.wb_valid), 256'(1'b1));
      stim[2] = mkBeat(2, 51, 1'b1, 1'b0, 1'b0);
      applyStimulus(4'b0100);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("mid_async_valid", 256'(bus.wb_valid), 256'(1'b0));
      checkOutput("mid_async_cnt", 256'(wbCount), 256'(0));
      modelReset();
      applyStimulus('0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      stim[0] = mkBeat(0, 52, 1'b1, 1'b1, 1'b1);
      stim[2] = mkBeat(2, 53, 1'b1, 1'b1, 1'b1);
      applyStimulus(4'b0101);
      step(rdy);
      checkOutput("mid_after_grant", 256'(rdy), 256'(4'b0001));

      // Counter wrap: 17 written beats on a 4-bit counter.
      doReset();
      for (int i = 0; i < 17; i++) begin
         stim[0] = mkBeat(0, 60 + i, 1'b1, 1'b1, 1'b1);
         applyStimulus(4'b0001);
         step(rdy);
      end
      checkOutput("wrap_cnt", 256'(wbCount), 256'(4'd1));

      applyStimulus('0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
